// File: rtl/fft_bin_streamer_pkg.sv
// Shared constants and state type for the FFT bin streamer slice.
package fft_bin_streamer_pkg;
    localparam int unsigned N          = 32;
    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned BIN_W      = $clog2(N);
    localparam int unsigned MAG_W      = DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        REPORT
    } strm_state_t;
endpackage

// File: rtl/fft_bin_streamer_if.sv
// Streamed-bin and peak-report bundle between the streamer and its consumer.
interface fft_bin_streamer_if;
    import fft_bin_streamer_pkg::*;

    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_real;
    logic signed [DATA_WIDTH-1:0] out_imag;
    logic        [MAG_W-1:0]      out_mag;
    logic        [BIN_W-1:0]      out_bin;
    logic                         out_last;
    logic                         peak_valid;
    logic        [BIN_W-1:0]      peak_bin;
    logic        [MAG_W-1:0]      peak_mag;

    modport master (
        output out_valid, out_real, out_imag, out_mag, out_bin, out_last,
        output peak_valid, peak_bin, peak_mag,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_real, out_imag, out_mag, out_bin, out_last,
        input  peak_valid, peak_bin, peak_mag,
        output out_ready
    );
endinterface

// File: rtl/fft_bin_streamer_mag.sv
// Combinational scaling of one complex bin plus its |re|+|im| magnitude.
module fft_bin_mag
    import fft_bin_streamer_pkg::*;
#(
    parameter int unsigned SHIFT = 3
) (
    input  logic signed [DATA_WIDTH-1:0] re_i,
    input  logic signed [DATA_WIDTH-1:0] im_i,
    output logic signed [DATA_WIDTH-1:0] re_o,
    output logic signed [DATA_WIDTH-1:0] im_o,
    output logic        [MAG_W-1:0]      mag_o
);
    logic signed [MAG_W-1:0] re_x, im_x;
    logic        [MAG_W-1:0] re_abs, im_abs;

    always_comb begin
        re_o   = re_i >>> SHIFT;
        im_o   = im_i >>> SHIFT;
        // One extra bit so that negating -2^(W-1) is exact
        re_x   = MAG_W'(re_o);
        im_x   = MAG_W'(im_o);
        re_abs = re_x[MAG_W-1] ? MAG_W'(-re_x) : MAG_W'(re_x);
        im_abs = im_x[MAG_W-1] ? MAG_W'(-im_x) : MAG_W'(im_x);
        mag_o  = re_abs + im_abs;
    end
endmodule

// File: rtl/fft_bin_streamer.sv
// Snapshots an FFT frame, streams scaled bins with magnitude, then reports the peak bin.
module fft_bin_streamer
    import fft_bin_streamer_pkg::*;
#(
    parameter int unsigned SHIFT     = 3,
    parameter bit          PEAK_HALF = 1'b1
) (
    input  logic                      clk_100mhz,
    input  logic                      rst_n,
    input  logic [N*DATA_WIDTH-1:0]   fft_real_flat,
    input  logic [N*DATA_WIDTH-1:0]   fft_imag_flat,
    input  logic                      fft_out_valid,
    output logic                      frame_ready,
    output logic                      overflow,
    fft_bin_streamer_if.master        strm
);
    strm_state_t              state_q, state_d;
    logic [BIN_W-1:0]         idx_q, idx_d;
    logic [BIN_W-1:0]         pk_bin_q, pk_bin_d;
    logic [MAG_W-1:0]         pk_mag_q, pk_mag_d;
    logic                     ovf_q, ovf_d;
    logic                     capture;
    logic                     handshake;
    logic                     in_range;

    logic signed [DATA_WIDTH-1:0] re_bank_q [N];
    logic signed [DATA_WIDTH-1:0] im_bank_q [N];
    logic signed [DATA_WIDTH-1:0] cur_re, cur_im;
    logic        [MAG_W-1:0]      cur_mag;

    fft_bin_mag #(.SHIFT(SHIFT)) u_mag (
        .re_i  (re_bank_q[idx_q]),
        .im_i  (im_bank_q[idx_q]),
        .re_o  (cur_re),
        .im_o  (cur_im),
        .mag_o (cur_mag)
    );

    assign handshake = (state_q == STREAM) && strm.out_ready;
    assign in_range  = PEAK_HALF ? (idx_q <= BIN_W'(N / 2)) : 1'b1;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pk_bin_d = pk_bin_q;
        pk_mag_d = pk_mag_q;
        ovf_d    = ovf_q;
        capture  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fft_out_valid) begin
                    capture  = 1'b1;
                    idx_d    = '0;
                    pk_bin_d = '0;
                    pk_mag_d = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (handshake) begin
                    idx_d = idx_q + BIN_W'(1);
                    // Bin 0 always seeds the search; strict > keeps the lowest bin on ties
                    if (in_range && (cur_mag > pk_mag_q || idx_q == '0)) begin
                        pk_bin_d = idx_q;
                        pk_mag_d = cur_mag;
                    end
                    if (idx_q == BIN_W'(N - 1)) begin
                        state_d = REPORT;
                    end
                end
            end
            REPORT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (fft_out_valid && state_q != IDLE) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            pk_bin_q <= '0;
            pk_mag_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pk_bin_q <= pk_bin_d;
            pk_mag_q <= pk_mag_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N; k++) begin
                re_bank_q[k] <= '0;
                im_bank_q[k] <= '0;
            end
        end else if (capture) begin
            for (int unsigned k = 0; k < N; k++) begin
                re_bank_q[k] <= fft_real_flat[k*DATA_WIDTH +: DATA_WIDTH];
                im_bank_q[k] <= fft_imag_flat[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign frame_ready     = (state_q == IDLE);
    assign overflow        = ovf_q;
    assign strm.out_valid  = (state_q == STREAM);
    assign strm.out_real   = cur_re;
    assign strm.out_imag   = cur_im;
    assign strm.out_mag    = cur_mag;
    assign strm.out_bin    = idx_q;
    assign strm.out_last   = (state_q == STREAM) && (idx_q == BIN_W'(N - 1));
    assign strm.peak_valid = (state_q == REPORT);
    assign strm.peak_bin   = pk_bin_q;
    assign strm.peak_mag   = pk_mag_q;
endmodule

// File: tb/tb_fft_bin_streamer.sv
// Bench for fft_bin_streamer: two parameterisations against a frame-level reference model.
module tb_fft_bin_streamer;
    import fft_bin_streamer_pkg::*;

    localparam int MS_IDLE = 0, MS_STREAM = 1, MS_REPORT = 2;

    logic clk = 1'b0;
    logic rst_n, fov, ready;
    logic [N*DATA_WIDTH-1:0] real_flat, imag_flat;
    logic fr_a, fr_b, ovf_a, ovf_b;

    always #5 clk = ~clk;

    fft_bin_streamer_if ifa ();
    fft_bin_streamer_if ifb ();
    assign ifa.out_ready = ready;
    assign ifb.out_ready = ready;

    fft_bin_streamer #(.SHIFT(3), .PEAK_HALF(1'b1)) dut_a (
        .clk_100mhz(clk), .rst_n(rst_n), .fft_real_flat(real_flat), .fft_imag_flat(imag_flat),
        .fft_out_valid(fov), .frame_ready(fr_a), .overflow(ovf_a), .strm(ifa.master)
    );
    fft_bin_streamer #(.SHIFT(0), .PEAK_HALF(1'b0)) dut_b (
        .clk_100mhz(clk), .rst_n(rst_n), .fft_real_flat(real_flat), .fft_imag_flat(imag_flat),
        .fft_out_valid(fov), .frame_ready(fr_b), .overflow(ovf_b), .strm(ifb.master)
    );

    int n_chk = 0, n_bad = 0;
    int fr_re [N], fr_im [N];
    int mre [N], mim [N];
    int m_st = MS_IDLE, m_idx = 0, m_ovf = 0;
    int m_pbin [2] = '{0, 0};
    int m_pmag [2] = '{0, 0};
    int hs_cnt = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int sh_of(input int d);
        return (d == 0) ? 3 : 0;
    endfunction

    function automatic int exp_part(input int v, input int d);
        return v >>> sh_of(d);
    endfunction

    function automatic int emag(input int d, input int k);
        int r, i;
        r = exp_part(mre[k], d);
        i = exp_part(mim[k], d);
        if (r < 0) r = -r;
        if (i < 0) i = -i;
        return r + i;
    endfunction

    task automatic find_peaks();
        for (int d = 0; d < 2; d++) begin
            int lim, best, bm;
            lim  = (d == 0) ? N / 2 : N - 1;
            best = 0;
            bm   = emag(d, 0);
            for (int k = 1; k <= lim; k++) begin
                if (emag(d, k) > bm) begin
                    bm   = emag(d, k);
                    best = k;
                end
            end
            m_pbin[d] = best;
            m_pmag[d] = bm;
        end
    endtask

    task automatic check_dut(input int d, input logic fr, input logic ov, input logic vld,
                             input logic last, input logic pv,
                             input logic [DATA_WIDTH-1:0] re, input logic [DATA_WIDTH-1:0] im,
                             input logic [MAG_W-1:0] mag, input logic [BIN_W-1:0] bin,
                             input logic [BIN_W-1:0] pbin, input logic [MAG_W-1:0] pmag);
        string p;
        p = (d == 0) ? "a_" : "b_";
        chk({p, "frame_ready"}, longint'(fr), longint'(m_st == MS_IDLE));
        chk({p, "overflow"},    longint'(ov), longint'(m_ovf));
        chk({p, "out_valid"},   longint'(vld), longint'(m_st == MS_STREAM));
        chk({p, "out_last"},    longint'(last), longint'(m_st == MS_STREAM && m_idx == N - 1));
        chk({p, "peak_valid"},  longint'(pv), longint'(m_st == MS_REPORT));
        if (m_st == MS_STREAM) begin
            chk({p, "out_bin"},  longint'(bin), longint'(m_idx));
            chk({p, "out_real"}, longint'($signed(re)), longint'(exp_part(mre[m_idx], d)));
            chk({p, "out_imag"}, longint'($signed(im)), longint'(exp_part(mim[m_idx], d)));
            chk({p, "out_mag"},  longint'(mag), longint'(emag(d, m_idx)));
        end else begin
            chk({p, "peak_bin"}, longint'(pbin), longint'(m_pbin[d]));
            chk({p, "peak_mag"}, longint'(pmag), longint'(m_pmag[d]));
        end
    endtask

    task automatic model_update();
        if (!rst_n) begin
            m_st = MS_IDLE; m_idx = 0; m_ovf = 0;
            m_pbin = '{0, 0};
            m_pmag = '{0, 0};
        end else begin
            case (m_st)
                MS_IDLE: if (fov) begin
                    for (int k = 0; k < N; k++) begin
                        mre[k] = $signed(real_flat[k*DATA_WIDTH +: DATA_WIDTH]);
                        mim[k] = $signed(imag_flat[k*DATA_WIDTH +: DATA_WIDTH]);
                    end
                    m_idx = 0;
                    m_st  = MS_STREAM;
                end
                MS_STREAM: begin
                    if (fov) m_ovf = 1;
                    if (ready) begin
                        if (m_idx == N - 1) begin
                            m_st = MS_REPORT;
                            find_peaks();
                        end
                        m_idx = (m_idx + 1) % N;
                    end
                end
                default: begin
                    if (fov) m_ovf = 1;
                    m_st = MS_IDLE;
                end
            endcase
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_dut(0, fr_a, ovf_a, ifa.out_valid, ifa.out_last, ifa.peak_valid, ifa.out_real,
                  ifa.out_imag, ifa.out_mag, ifa.out_bin, ifa.peak_bin, ifa.peak_mag);
        check_dut(1, fr_b, ovf_b, ifb.out_valid, ifb.out_last, ifb.peak_valid, ifb.out_real,
                  ifb.out_imag, ifb.out_mag, ifb.out_bin, ifb.peak_bin, ifb.peak_mag);
        if (ifa.out_valid && ready) hs_cnt++;
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame();
        for (int k = 0; k < N; k++) begin
            real_flat[k*DATA_WIDTH +: DATA_WIDTH] = fr_re[k][DATA_WIDTH-1:0];
            imag_flat[k*DATA_WIDTH +: DATA_WIDTH] = fr_im[k][DATA_WIDTH-1:0];
        end
    endtask

    // rmode: 0 always ready, 1 pattern 1,0,0, 2 random; ovf_at/rst_at < 0 disables injection
    task automatic send_frame(input int rmode, input int ovf_at, input int rst_at);
        bit done, inj_o, inj_r;
        done = 0; inj_o = 0; inj_r = 0;
        load_frame();
        fov = 1'b1;
        step();
        fov = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            case (rmode)
                0: ready = 1'b1;
                1: ready = (c % 3 == 0);
                default: ready = ($urandom_range(0, 3) != 0);
            endcase
            if (ovf_at >= 0 && !inj_o && m_st == MS_STREAM && m_idx == ovf_at) begin
                inj_o = 1;
                fov = 1'b1;
                real_flat = {N{16'h5A5A}};
            end
            if (rst_at >= 0 && !inj_r && m_st == MS_STREAM && m_idx == rst_at) begin
                inj_r = 1;
                rst_n = 1'b0;
            end
            step();
            fov = 1'b0;
            rst_n = 1'b1;
            if (m_st == MS_IDLE) done = 1;
        end
        if (!done) chk("frame_timeout", 0, 1);
        ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; fov = 1'b0; ready = 1'b0;
        real_flat = '0; imag_flat = '0;
        @(posedge clk);
        #1;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Ramp, continuous ready
        for (int k = 0; k < N; k++) begin fr_re[k] = k * 8; fr_im[k] = 0; end
        send_frame(0, -1, -1);
        chk("ramp_peak_bin_a", longint'(ifa.peak_bin), 16);
        chk("ramp_peak_mag_a", longint'(ifa.peak_mag), 16);
        chk("ramp_peak_bin_b", longint'(ifb.peak_bin), 31);
        chk("ramp_peak_mag_b", longint'(ifb.peak_mag), 248);

        // Backpressure 1,0,0 with random data, back-to-back after previous frame
        for (int k = 0; k < N; k++) begin
            fr_re[k] = int'($urandom_range(0, 65535)) - 32768;
            fr_im[k] = int'($urandom_range(0, 65535)) - 32768;
        end
        hs_cnt = 0;
        send_frame(1, -1, -1);
        chk("bp_handshakes", hs_cnt, 32);

        // Extremes: full negative bin at SHIFT=0
        for (int k = 0; k < N; k++) begin fr_re[k] = 0; fr_im[k] = 0; end
        fr_re[5] = -32768; fr_im[5] = -32768;
        send_frame(2, -1, -1);
        chk("ext_peak_bin_b", longint'(ifb.peak_bin), 5);
        chk("ext_peak_mag_b", longint'(ifb.peak_mag), 65536);

        // Tie between bins 3 and 7
        for (int k = 0; k < N; k++) begin fr_re[k] = 0; fr_im[k] = 0; end
        fr_re[1] = 80; fr_re[3] = 800; fr_re[7] = 400; fr_im[7] = -400;
        send_frame(0, -1, -1);
        chk("tie_peak_bin_a", longint'(ifa.peak_bin), 3);
        chk("tie_peak_mag_a", longint'(ifa.peak_mag), 100);

        // Overflow: second frame arrives at bin 10
        for (int k = 0; k < N; k++) begin fr_re[k] = k * 100 - 1600; fr_im[k] = 3 * k; end
        send_frame(2, 10, -1);
        chk("ovf_sticky_a", longint'(ovf_a), 1);
        for (int i = 0; i < 3; i++) step();
        send_frame(0, -1, -1);

        // Mid-stream reset at bin 12
        send_frame(0, -1, 12);
        chk("rst_ovf_cleared", longint'(ovf_a), 0);
        for (int i = 0; i < 3; i++) step();

        // Random frames with random backpressure and occasional overflow
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < N; k++) begin
                fr_re[k] = int'($urandom_range(0, 65535)) - 32768;
                fr_im[k] = int'($urandom_range(0, 65535)) - 32768;
            end
            send_frame(2, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1, -1);
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
